// File: rtl/regfile_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_pkg : shared constants, types and write-port winner select |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
package regfile_pkg;

  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_NUM_REGS = 8;
  localparam int unsigned MAX_PORTS    = 32;
  localparam int unsigned PORT_IDX_W   = $clog2(MAX_PORTS);

  typedef logic [$clog2(DEF_NUM_REGS)-1:0] rf_addr_t;

  // Highest set bit of a match vector; callers qualify the result with |match.
  function automatic logic [PORT_IDX_W-1:0] win_sel(input logic [MAX_PORTS-1:0] i_match);
    logic [PORT_IDX_W-1:0] w_idx;
    w_idx = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (i_match[i]) w_idx = PORT_IDX_W'(i);
    end
    return w_idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_scoreboard : per-register busy bits, reserve error, lookup |
// | Revision           : 1.0                                           |
// +--------------------------------------------------------------------+
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned NUM_RD   = 3,
  parameter bit          ZERO_REG = 1'b0,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REGS-1:0]  i_clr,
  input  logic                 i_rsv_en,
  input  logic [AW-1:0]        i_rsv_addr,
  input  logic [NUM_RD-1:0]    i_rd_en,
  input  logic [NUM_RD*AW-1:0] i_rd_addr,
  output logic [NUM_RD-1:0]    o_rd_busy,
  output logic                 o_rsv_err
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_cleared;
  logic [NUM_REGS-1:0] w_set;
  logic                w_rsv_ok;
  logic                r_rsv_err;

  // Writes clear first; the reserve then sets on top of the cleared view.
  assign w_busy_cleared = r_busy & ~i_clr;
  assign w_rsv_ok       = i_rsv_en && !(ZERO_REG && (i_rsv_addr == '0));

  always_comb begin
    w_set = '0;
    if (w_rsv_ok) w_set[i_rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= '0;
      r_rsv_err <= 1'b0;
    end else begin
      r_busy    <= w_busy_cleared | w_set;
      r_rsv_err <= w_rsv_ok && w_busy_cleared[i_rsv_addr];
    end
  end

  generate
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_busy
      assign o_rd_busy[p] = i_rd_en[p] && w_busy_cleared[i_rd_addr[p*AW +: AW]];
    end
  endgenerate

  assign o_rsv_err = r_rsv_err;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_mp : multi-port register file with write-through bypass    |
// |              and busy scoreboard                                   |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned NUM_RD   = 3,
  parameter int unsigned NUM_WR   = 2,
  parameter bit          ZERO_REG = 1'b0,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        i_rd_en,
  input  logic [NUM_RD*AW-1:0]     i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_busy,
  input  logic [NUM_WR-1:0]        i_wr_en,
  input  logic [NUM_WR*AW-1:0]     i_wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
  output logic [NUM_WR-1:0]        o_wr_ack,
  output logic                     o_wr_conflict,
  input  logic                     i_rsv_en,
  input  logic [AW-1:0]            i_rsv_addr,
  output logic                     o_rsv_err
);

  logic [DATA_W-1:0]   r_mem [NUM_REGS];
  logic [AW-1:0]       w_wr_addr [NUM_WR];
  logic [DATA_W-1:0]   w_wr_data [NUM_WR];
  logic [AW-1:0]       w_rd_addr [NUM_RD];
  logic [NUM_WR-1:0]   w_wr_win;
  logic [NUM_WR-1:0]   w_wr_commit;
  logic [NUM_REGS-1:0] w_clr;
  logic                w_conflict;
  logic [NUM_WR-1:0]   r_wr_ack;
  logic                r_wr_conflict;

  generate
    for (genvar w = 0; w < NUM_WR; w++) begin : g_wr_unpack
      assign w_wr_addr[w] = i_wr_addr[w*AW +: AW];
      assign w_wr_data[w] = i_wr_data[w*DATA_W +: DATA_W];
    end
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_unpack
      assign w_rd_addr[p] = i_rd_addr[p*AW +: AW];
    end
  endgenerate

  // A port wins when it is the highest enabled port targeting its address.
  generate
    for (genvar w = 0; w < NUM_WR; w++) begin : g_wr_arb
      logic [NUM_WR-1:0] w_same;
      always_comb begin
        for (int v = 0; v < NUM_WR; v++) begin
          w_same[v] = i_wr_en[v] && (w_wr_addr[v] == w_wr_addr[w]);
        end
      end
      assign w_wr_win[w]    = i_wr_en[w] && (int'(win_sel(MAX_PORTS'(w_same))) == w);
      assign w_wr_commit[w] = w_wr_win[w] && !(ZERO_REG && (w_wr_addr[w] == '0));
    end
  endgenerate

  assign w_conflict = |(i_wr_en & ~w_wr_win);

  always_comb begin
    w_clr = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (w_wr_commit[w]) w_clr[w_wr_addr[w]] = 1'b1;
    end
  end

  // Winners always target distinct addresses, so loop order is irrelevant here.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) r_mem[r] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (w_wr_commit[w]) r_mem[w_wr_addr[w]] <= w_wr_data[w];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ack      <= '0;
      r_wr_conflict <= 1'b0;
    end else begin
      r_wr_ack      <= w_wr_win;
      r_wr_conflict <= w_conflict;
    end
  end

  generate
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [NUM_WR-1:0]     w_hit;
      logic [PORT_IDX_W-1:0] w_sel;
      logic [DATA_W-1:0]     w_data;
      always_comb begin
        for (int v = 0; v < NUM_WR; v++) begin
          w_hit[v] = i_wr_en[v] && (w_wr_addr[v] == w_rd_addr[p]);
        end
      end
      assign w_sel = win_sel(MAX_PORTS'(w_hit));
      always_comb begin
        w_data = r_mem[w_rd_addr[p]];
        for (int v = 0; v < NUM_WR; v++) begin
          if (w_hit[v] && (int'(w_sel) == v)) w_data = w_wr_data[v];
        end
        if (!i_rd_en[p] || (ZERO_REG && (w_rd_addr[p] == '0))) w_data = '0;
      end
      assign o_rd_data[p*DATA_W +: DATA_W] = w_data;
    end
  endgenerate

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_clr),
    .i_rsv_en   (i_rsv_en),
    .i_rsv_addr (i_rsv_addr),
    .i_rd_en    (i_rd_en),
    .i_rd_addr  (i_rd_addr),
    .o_rd_busy  (o_rd_busy),
    .o_rsv_err  (o_rsv_err)
  );

  assign o_wr_ack      = r_wr_ack;
  assign o_wr_conflict = r_wr_conflict;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_regfile_mp : directed bench with a reference model of regfile_mp|
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module tb_regfile_mp;

  localparam int DW  = 16;
  localparam int NR  = 8;
  localparam int NRD = 3;
  localparam int NWR = 2;
  localparam int AW  = 3;
  localparam bit ZR  = 1'b1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD-1:0]    rd_en;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic [NWR-1:0]    wr_ack;
  logic              wr_conflict;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic              rsv_err;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0]  m_mem [NR];
  logic [NR-1:0]  m_busy;
  logic [NWR-1:0] m_ack;
  logic           m_conf;
  logic           m_err;
  bit             m_valid = 1'b0;

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_W   (DW),
    .NUM_REGS (NR),
    .NUM_RD   (NRD),
    .NUM_WR   (NWR),
    .ZERO_REG (ZR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_rd_en       (rd_en),
    .i_rd_addr     (rd_addr),
    .o_rd_data     (rd_data),
    .o_rd_busy     (rd_busy),
    .i_wr_en       (wr_en),
    .i_wr_addr     (wr_addr),
    .i_wr_data     (wr_data),
    .o_wr_ack      (wr_ack),
    .o_wr_conflict (wr_conflict),
    .i_rsv_en      (rsv_en),
    .i_rsv_addr    (rsv_addr),
    .o_rsv_err     (rsv_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] wa(input int w); return wr_addr[w*AW +: AW]; endfunction
  function automatic logic [DW-1:0] wd(input int w); return wr_data[w*DW +: DW]; endfunction
  function automatic logic [AW-1:0] ra(input int p); return rd_addr[p*AW +: AW]; endfunction
  function automatic logic [DW-1:0] rdp(input int p); return rd_data[p*DW +: DW]; endfunction

  function automatic bit hard_zero(input logic [AW-1:0] a);
    return ZR && (a == '0);
  endfunction

  // Any enabled write reaching a real register this cycle (a loser shares the winner's address).
  function automatic bit written(input logic [AW-1:0] a);
    for (int w = 0; w < NWR; w++) if (wr_en[w] && wa(w) == a && !hard_zero(a)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] exp_data(input int p);
    logic [DW-1:0] d;
    if (!rd_en[p] || hard_zero(ra(p))) return '0;
    d = m_mem[ra(p)];
    for (int w = 0; w < NWR; w++) if (wr_en[w] && wa(w) == ra(p)) d = wd(w);
    return d;
  endfunction

  function automatic logic exp_busy(input int p);
    return rd_en[p] && m_busy[ra(p)] && !written(ra(p));
  endfunction

  always @(posedge clk) begin
    logic [NR-1:0]  wmask;
    logic [NWR-1:0] ack;
    if (rst) begin
      for (int r = 0; r < NR; r++) m_mem[r] = '0;
      m_busy  = '0;
      m_ack   = '0;
      m_conf  = 1'b0;
      m_err   = 1'b0;
      m_valid = 1'b1;
    end else begin
      wmask = '0;
      for (int w = 0; w < NWR; w++) begin
        ack[w] = wr_en[w];
        for (int v = w + 1; v < NWR; v++) if (wr_en[v] && wa(v) == wa(w)) ack[w] = 1'b0;
      end
      m_conf = |(wr_en & ~ack);
      for (int w = 0; w < NWR; w++) begin
        if (ack[w] && !hard_zero(wa(w))) begin
          m_mem[wa(w)] = wd(w);
          wmask[wa(w)] = 1'b1;
        end
      end
      m_err  = rsv_en && !hard_zero(rsv_addr) && m_busy[rsv_addr] && !wmask[rsv_addr];
      m_busy = m_busy & ~wmask;
      if (rsv_en && !hard_zero(rsv_addr)) m_busy[rsv_addr] = 1'b1;
      m_ack = ack;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      for (int p = 0; p < NRD; p++) begin
        check($sformatf("model rd_data[%0d]", p), 32'(rdp(p)), 32'(exp_data(p)));
        check($sformatf("model rd_busy[%0d]", p), 32'(rd_busy[p]), 32'(exp_busy(p)));
      end
      check("model wr_ack", 32'(wr_ack), 32'(m_ack));
      check("model wr_conflict", 32'(wr_conflict), 32'(m_conf));
      check("model rsv_err", 32'(rsv_err), 32'(m_err));
    end
  end

  task automatic idle();
    rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask
  task automatic rd(input int p, input int a);
    rd_en[p] = 1'b1; rd_addr[p*AW +: AW] = AW'(a);
  endtask
  task automatic wr(input int w, input int a, input logic [DW-1:0] d);
    wr_en[w] = 1'b1; wr_addr[w*AW +: AW] = AW'(a); wr_data[w*DW +: DW] = d;
  endtask
  task automatic rsv(input int a);
    rsv_en = 1'b1; rsv_addr = AW'(a);
  endtask
  task automatic next();
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) next();
    rst = 1'b0;

    for (int r = 0; r < NR; r++) begin
      idle(); rd(0, r); rd(1, (r + 3) % NR); rd(2, (r + 5) % NR);
      @(negedge clk);
      for (int p = 0; p < NRD; p++) begin
        check("reset rd_data", 32'(rdp(p)), 'h0);
        check("reset rd_busy", 32'(rd_busy[p]), 'h0);
      end
      if (r == 0) begin
        check("reset wr_ack", 32'(wr_ack), 'h0);
        check("reset wr_conflict", 32'(wr_conflict), 'h0);
        check("reset rsv_err", 32'(rsv_err), 'h0);
      end
      next();
    end

    idle(); wr(0, 3, 16'h1234); rd(0, 3);
    @(negedge clk); check("bypass r3", 32'(rdp(0)), 'h1234);
    next();
    idle(); rd(0, 3);
    @(negedge clk); check("stored r3", 32'(rdp(0)), 'h1234); check("ack r3", 32'(wr_ack), 'b01);
    next();

    idle(); wr(0, 5, 16'hAAAA); wr(1, 5, 16'h5555); rd(1, 5);
    @(negedge clk); check("collide bypass r5", 32'(rdp(1)), 'h5555);
    next();
    idle(); rd(1, 5);
    @(negedge clk);
    check("collide stored r5", 32'(rdp(1)), 'h5555);
    check("collide ack", 32'(wr_ack), 'b10);
    check("collide conflict", 32'(wr_conflict), 'h1);
    next();

    idle(); rsv(2);
    @(negedge clk); next();
    idle(); rsv(2); rd(2, 2);
    @(negedge clk); check("busy r2", 32'(rd_busy[2]), 'h1); check("first rsv_err", 32'(rsv_err), 'h0);
    next();
    idle(); wr(0, 2, 16'h0042); rd(2, 2);
    @(negedge clk);
    check("double rsv_err", 32'(rsv_err), 'h1);
    check("busy r2 cleared by write", 32'(rd_busy[2]), 'h0);
    check("bypass r2", 32'(rdp(2)), 'h0042);
    next();
    idle(); rd(2, 2);
    @(negedge clk); check("busy r2 after", 32'(rd_busy[2]), 'h0); check("rsv_err drop", 32'(rsv_err), 'h0);
    next();

    idle(); wr(1, 0, 16'hFFFF); rd(0, 0);
    @(negedge clk); check("r0 no bypass", 32'(rdp(0)), 'h0);
    next();
    idle(); rsv(0); rd(0, 0);
    @(negedge clk); check("r0 write ack", 32'(wr_ack), 'b10); check("r0 stays 0", 32'(rdp(0)), 'h0);
    next();
    idle(); rd(0, 0);
    @(negedge clk); check("r0 never busy", 32'(rd_busy[0]), 'h0); check("r0 rsv_err", 32'(rsv_err), 'h0);
    next();

    idle(); wr(0, 4, 16'h4444); rsv(4);
    @(negedge clk); next();
    idle(); rd(0, 4);
    @(negedge clk);
    check("wr+rsv busy", 32'(rd_busy[0]), 'h1);
    check("wr+rsv err", 32'(rsv_err), 'h0);
    check("wr+rsv data", 32'(rdp(0)), 'h4444);
    next();

    idle(); wr(0, 1, 16'h1111);
    @(negedge clk); next();
    idle(); wr(0, 1, 16'h0BAD); rst = 1'b1;
    @(negedge clk); check("ack before rst", 32'(wr_ack), 'b01);
    next();
    rst = 1'b0; idle(); rd(0, 1); rd(1, 4);
    @(negedge clk);
    check("rst drops ack", 32'(wr_ack), 'h0);
    check("rst drops write", 32'(rdp(0)), 'h0);
    check("rst clears busy", 32'(rd_busy[1]), 'h0);
    next();
    idle(); wr(0, 6, 16'h7777);
    @(negedge clk); next();
    idle(); rd(0, 6);
    @(negedge clk); check("post-rst ack", 32'(wr_ack), 'b01); check("post-rst data", 32'(rdp(0)), 'h7777);
    next();

    for (int i = 0; i < 60; i++) begin
      rd_en    = NRD'($urandom);
      rd_addr  = (NRD*AW)'($urandom);
      wr_en    = NWR'($urandom);
      wr_addr  = (NWR*AW)'($urandom);
      wr_data  = (NWR*DW)'($urandom);
      rsv_en   = 1'($urandom);
      rsv_addr = AW'($urandom);
      @(negedge clk);
      next();
    end

    idle();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file with write-through bypass and a per-register busy scoreboard. It is the next-generation GPR store for the execute stage. It serves NUM_RD combinational read ports and NUM_WR registered write ports. Each write is acknowledged one cycle later. Registers can be reserved as "pending" by issue logic until a writeback clears them.

## Interface
- DATA_W, 16: register width in bits.
- NUM_REGS, 8: register count, power of two, ≥2; AW = $clog2(NUM_REGS).
- NUM_RD, 3: read ports.
- NUM_WR, 2: write ports, ≥1.
- ZERO_REG, 0: if 1, register 0 reads as 0, ignores writes and is never busy.
- clk in 1: clock, all state updates on rising edge.
- rst in 1: reset, synchronous, active-high.
- rd_en in NUM_RD: per-port read enable.
- rd_addr in NUM_RD×AW: read addresses.
- rd_data out NUM_RD×DATA_W: read data; 0 when rd_en low.
- rd_busy out NUM_RD: addressed register is reserved; 0 when rd_en low.
- wr_en in NUM_WR: per-port write strobe.
- wr_addr in NUM_WR×AW: write addresses.
- wr_data in NUM_WR×DATA_W: write data.
- wr_ack out NUM_WR: registered; 1 the cycle after a write that committed.
- wr_conflict out 1: registered; 1 the cycle after any same-address write collision.
- rsv_en in 1: reserve register rsv_addr.
- rsv_addr in AW: register to mark busy.
- rsv_err out 1: registered; 1 the cycle after a reserve of an already-busy register.

## Operation
- Storage: NUM_REGS×DATA_W flops, plus a busy vector of NUM_REGS bits.
- Read, combinational, per port p:
  - If rd_en[p] is low, rd_data[p]=0 and rd_busy[p]=0.
  - Otherwise, if any wr_en[w] targets rd_addr[p] this cycle, bypass: return the winning write's wr_data.
  - Otherwise return the stored value.
  - rd_busy[p] reflects busy *after* this cycle's writes clear, but before this cycle's reserve.
- Write:
  - Each wr_en[w] commits wr_data[w] to wr_addr[w] at the edge.
  - Same-address collision: the highest-indexed port wins. Losers get wr_ack=0 and wr_conflict=1 next cycle; the winner gets wr_ack=1.
- ZERO_REG=1 with address 0:
  - A write is dropped and gets wr_ack=1; the register stays 0.
  - A read returns 0 with no bypass.
  - A reserve is ignored and gets rsv_err=0.
- Scoreboard:
  - A committed write to register r clears busy[r].
  - rsv_en sets busy[rsv_addr].
  - Reserve and write to the same register in the same cycle: the write clears, then the reserve sets, so busy stays 1 and rsv_err=0.
  - Reserve of a register that is busy and not being written this cycle: rsv_err=1 next cycle, busy stays 1.
- Reset: all registers, busy bits, wr_ack, wr_conflict and rsv_err go to 0. Reset overrides same-cycle writes and reserves.

## Timing
- Read latency: 0 cycles (combinational, including the bypass).
- Write-to-read latency: 0 cycles via bypass; 1 cycle through storage.
- wr_ack, wr_conflict, rsv_err: 1-cycle pulses, valid the cycle after the event; all 0 out of reset.
- Busy set by a reserve is visible on rd_busy in the next cycle.
- Asserting rst in the middle of back-to-back writes: the write in the rst cycle is lost and its ack is 0. The first post-reset write acks normally.
- No stall or backpressure; every write and reserve is accepted in the cycle it is presented.

## Structure
- Shared package regfile_pkg: rf_addr_t typedef as a function of NUM_REGS, default DATA_W/NUM_REGS constants, and a winner-select function (highest index match).
- Sub-module regfile_scoreboard: busy vector, clear and reserve ordering, rsv_err, ZERO_REG masking, and the busy lookup per read port.
- Top level: storage array, write arbitration, bypass muxes, ack/conflict registers.

## Test plan
- Reset, then read all 8 registers on 3 ports → all data 0, busy 0, wr_ack/wr_conflict/rsv_err 0.
- Write port0 r3=0x1234; read r3 the same cycle → 0x1234 (bypass). Next cycle: wr_ack[0]=1, storage read returns 0x1234.
- Both ports write r5 (port0=0xAAAA, port1=0x5555) → reads give 0x5555; next cycle wr_ack=2'b10, wr_conflict=1.
- Reserve r2 → next cycle rd_busy=1. Reserve r2 again → rsv_err=1. Write r2=0x0042 → rd_busy=0 that cycle, value 0x0042.
- ZERO_REG=1: write r0=0xFFFF → wr_ack=1, r0 reads 0. Reserve r0 → busy 0, rsv_err 0.
- Write r1=0x0BAD with rst high the same cycle → r1=0 and wr_ack=0 next cycle.
